// File: rtl/common_fifo_rr_wr_arbiter_if.sv
// common_fifo_rr_wr_arbiter_if: requester handshakes and FIFO write port of the round-robin write arbiter
interface common_fifo_rr_wr_arbiter_if #(
    parameter int REQ_COUNT  = 2,
    parameter int DATA_WIDTH = 1,
    parameter int ID_WIDTH   = 1
);
    logic [REQ_COUNT-1:0]            req_valid;
    logic [REQ_COUNT*DATA_WIDTH-1:0] req_data;
    logic [REQ_COUNT-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]           fifo_din;
    logic                            fifo_wen;
    logic                            fifo_full;
    logic [ID_WIDTH-1:0]             out_src;
    logic                            busy;
    modport master (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_din, fifo_wen, out_src, busy
    );
    modport slave (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_din, fifo_wen, out_src, busy
    );
endinterface

// File: rtl/common_fifo_rr_wr_arbiter.sv
// common_fifo_rr_wr_arbiter: round-robin arbiter feeding one shifting FIFO write port through a one-entry output register
module common_fifo_rr_wr_arbiter #(
    parameter int REQ_COUNT  = 2,
    parameter int DATA_WIDTH = 1,
    parameter int ID_WIDTH   = 1
) (
    input logic                       clk,
    input logic                       reset,
    common_fifo_rr_wr_arbiter_if.slave bus
);
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d, win_data;
    logic [ID_WIDTH-1:0]   out_src_q, out_src_d, rr_ptr_q, rr_ptr_d, win;
    logic [REQ_COUNT-1:0]  ready;
    logic                  any_valid, push, load_en, grant;
    always_comb begin
        any_valid = 1'b0;
        win = '0;
        // lowest valid index below the pointer is the wrap-around fallback; lowest at/above it wins
        for (int j = REQ_COUNT - 1; j >= 0; j--)
            if (bus.req_valid[j] && ID_WIDTH'(j) < rr_ptr_q) begin
                win = ID_WIDTH'(j);
                any_valid = 1'b1;
            end
        for (int j = REQ_COUNT - 1; j >= 0; j--)
            if (bus.req_valid[j] && ID_WIDTH'(j) >= rr_ptr_q) begin
                win = ID_WIDTH'(j);
                any_valid = 1'b1;
            end
        win_data = '0;
        for (int j = 0; j < REQ_COUNT; j++)
            if (win == ID_WIDTH'(j)) win_data = bus.req_data[j*DATA_WIDTH +: DATA_WIDTH];
        push = out_valid_q & ~bus.fifo_full;
        load_en = ~out_valid_q | push;
        grant = reset & load_en & any_valid;
        ready = '0;
        for (int j = 0; j < REQ_COUNT; j++) ready[j] = grant && win == ID_WIDTH'(j);
        out_valid_d = grant | (out_valid_q & ~push);
        out_data_d = grant ? win_data : out_data_q;
        out_src_d = grant ? win : out_src_q;
        rr_ptr_d = grant ? ((win == ID_WIDTH'(REQ_COUNT - 1)) ? '0 : win + ID_WIDTH'(1)) : rr_ptr_q;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_data_q <= '0;
            out_src_q <= '0;
            rr_ptr_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q <= out_data_d;
            out_src_q <= out_src_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end
    assign bus.req_ready = ready;
    assign bus.fifo_wen = out_valid_q & reset;
    assign bus.fifo_din = out_data_q;
    assign bus.out_src = out_src_q;
    assign bus.busy = out_valid_q;
endmodule
